// File: rtl/laser_pkg.sv
// Shared constants and types for the laser job scheduler and its coverage engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package laser_pkg;

  localparam int COORD_W = 4;   // width of one point / centre coordinate
  localparam int POINTS  = 40;  // points per job; the engine loads exactly this many
  localparam int BEAT_W  = 6;   // beat counter width, covers 0..POINTS-1

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ARB,
    ST_LOAD,
    ST_WAIT_DONE,
    ST_RESP
  } state_t;

  // Two circle centres as reported by the engine on DONE.
  typedef struct packed {
    logic [COORD_W-1:0] c1x;
    logic [COORD_W-1:0] c1y;
    logic [COORD_W-1:0] c2x;
    logic [COORD_W-1:0] c2y;
  } circ_t;

endpackage

// File: rtl/laser_rr_arb.sv
// Round-robin pick: first set req bit searching upward from last_grant+1, with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the pick.
// Ports: req (request vector), last_grant (index of the previous owner),
//        found (any request), onehot (one-hot pick), idx (index of the pick).
module laser_rr_arb
  import laser_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic               found,
  output logic [NUM_REQ-1:0] onehot,
  output logic [ID_W-1:0]    idx
);

  int best;

  // Each requester's distance from last_grant+1 (mod NUM_REQ) is its priority
  // rank; the requesting one with the smallest rank wins, so the previous owner
  // always ranks last.
  always_comb begin
    best   = NUM_REQ;
    idx    = '0;
    found  = 1'b0;
    onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req[k] && ((k - int'(last_grant) - 1 + 2 * NUM_REQ) % NUM_REQ) < best) begin
        best = (k - int'(last_grant) - 1 + 2 * NUM_REQ) % NUM_REQ;
        idx  = ID_W'(k);
      end
    end
    found  = (best < NUM_REQ);
    onehot = found ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/laser_job_sched.sv
// Shares one two-circle coverage engine among NUM_REQ requesters: round-robin
// grant, forward POINTS beats to the engine, wait for DONE, return tagged result.
// Latency: grant one cycle after ARB; each accepted beat reaches the engine one
// cycle later; result registered the cycle after ENG_DONE.
// Backpressure: pready for the owner only, pvalid-independent; the result is
// held stable until res_ready, and no new job is granted before that handshake.
// Ports: req/grant (arbitration), pvalid/px/py/pready (per-requester point
// streams), ENG_* (engine load + result), res_* (tagged result), err_spurious.
module laser_job_sched
  import laser_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ID_W      = 1,
  parameter int POINTS    = laser_pkg::POINTS,
  parameter int INIT_WAIT = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  input  logic [NUM_REQ-1:0]         pvalid,
  input  logic [COORD_W*NUM_REQ-1:0] px,
  input  logic [COORD_W*NUM_REQ-1:0] py,
  output logic [NUM_REQ-1:0]         pready,
  output logic [COORD_W-1:0]         ENG_X,
  output logic [COORD_W-1:0]         ENG_Y,
  output logic                       ENG_VALID,
  input  logic                       ENG_DONE,
  input  logic [COORD_W-1:0]         ENG_C1X,
  input  logic [COORD_W-1:0]         ENG_C1Y,
  input  logic [COORD_W-1:0]         ENG_C2X,
  input  logic [COORD_W-1:0]         ENG_C2Y,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ID_W-1:0]            res_id,
  output logic [COORD_W-1:0]         res_c1x,
  output logic [COORD_W-1:0]         res_c1y,
  output logic [COORD_W-1:0]         res_c2x,
  output logic [COORD_W-1:0]         res_c2y,
  output logic                       err_spurious
);

  state_t              state, state_nxt;
  logic [7:0]          init_cnt;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [ID_W-1:0]     gidx;        // index of the current owner
  logic [ID_W-1:0]     last_grant;  // owner of the last completed job
  circ_t               res_q;

  logic                arb_found;
  logic [NUM_REQ-1:0]  arb_onehot;
  logic [ID_W-1:0]     arb_idx;

  logic [COORD_W-1:0]  sel_x, sel_y;
  logic                accept, last_beat;

  laser_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .found      (arb_found),
    .onehot     (arb_onehot),
    .idx        (arb_idx)
  );

  // Owner's point mux and ready. grant is one-hot and zero outside LOAD..RESP,
  // so gating it by the LOAD state gives a single ready bit at most.
  always_comb begin
    pready = '0;
    sel_x  = '0;
    sel_y  = '0;
    if (state == ST_LOAD && beat_cnt < BEAT_W'(POINTS)) begin
      pready = grant;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gidx == ID_W'(k)) begin
        sel_x = px[k*COORD_W +: COORD_W];
        sel_y = py[k*COORD_W +: COORD_W];
      end
    end
  end

  assign accept    = |(pvalid & pready);
  assign last_beat = accept && (beat_cnt == BEAT_W'(POINTS - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:      if (init_cnt == 8'(INIT_WAIT - 1)) state_nxt = ST_ARB;
      ST_ARB:       if (arb_found)                     state_nxt = ST_LOAD;
      ST_LOAD:      if (last_beat)                     state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (ENG_DONE)                      state_nxt = ST_RESP;
      ST_RESP:      if (res_valid && res_ready)        state_nxt = ST_ARB;
      default:                                         state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      init_cnt     <= '0;
      beat_cnt     <= '0;
      grant        <= '0;
      gidx         <= '0;
      // Previous owner = highest index, so requester 0 has first priority.
      last_grant   <= ID_W'(NUM_REQ - 1);
      ENG_VALID    <= 1'b0;
      ENG_X        <= '0;
      ENG_Y        <= '0;
      res_valid    <= 1'b0;
      res_id       <= '0;
      res_q        <= '0;
      err_spurious <= 1'b0;
    end else begin
      ENG_VALID <= accept;
      if (accept) begin
        ENG_X <= sel_x;
        ENG_Y <= sel_y;
      end

      case (state)
        ST_INIT: init_cnt <= init_cnt + 8'd1;
        ST_ARB: begin
          if (arb_found) begin
            grant <= arb_onehot;
            gidx  <= arb_idx;
          end
        end
        ST_LOAD: begin
          if (accept) beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
        end
        ST_WAIT_DONE: begin
          if (ENG_DONE) begin
            res_q     <= '{c1x: ENG_C1X, c1y: ENG_C1Y, c2x: ENG_C2X, c2y: ENG_C2Y};
            res_id    <= gidx;
            res_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (res_valid && res_ready) begin
            res_valid  <= 1'b0;
            grant      <= '0;
            last_grant <= gidx;
          end
        end
        default: ;
      endcase

      // A DONE we are not waiting for carries no usable data; just flag it.
      if (ENG_DONE && state != ST_WAIT_DONE) err_spurious <= 1'b1;
    end
  end

  assign res_c1x = res_q.c1x;
  assign res_c1y = res_q.c1y;
  assign res_c2x = res_q.c2x;
  assign res_c2y = res_q.c2y;

endmodule

// File: tb/tb_laser_job_sched.sv
module tb_laser_job_sched;
  import laser_pkg::*;

  localparam int N    = 2;
  localparam int IW   = 2;   // INIT_WAIT used for the DUT

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   req, grant, pvalid, pready;
  logic [4*N-1:0] px, py;
  logic [3:0]     ENG_X, ENG_Y;
  logic           ENG_VALID, ENG_DONE;
  logic [3:0]     ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y;
  logic           res_valid, res_ready;
  logic [0:0]     res_id;
  logic [3:0]     res_c1x, res_c1y, res_c2x, res_c2y;
  logic           err_spurious;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  laser_job_sched #(.NUM_REQ(N), .ID_W(1), .POINTS(POINTS), .INIT_WAIT(IW)) dut (
    .CLK(CLK), .RST(RST), .req(req), .grant(grant), .pvalid(pvalid), .px(px), .py(py),
    .pready(pready), .ENG_X(ENG_X), .ENG_Y(ENG_Y), .ENG_VALID(ENG_VALID),
    .ENG_DONE(ENG_DONE), .ENG_C1X(ENG_C1X), .ENG_C1Y(ENG_C1Y), .ENG_C2X(ENG_C2X),
    .ENG_C2Y(ENG_C2Y), .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_c1x(res_c1x), .res_c1y(res_c1y), .res_c2x(res_c2x), .res_c2y(res_c2y),
    .err_spurious(err_spurious)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int all_outs();
    return int'({grant, pready, ENG_VALID, ENG_X, ENG_Y, res_valid, res_id,
                 res_c1x, res_c1y, res_c2x, res_c2y, err_spurious});
  endfunction

  // One full job for requester g: points x=i%16, y=i/16.
  task automatic run_job(input logic [N-1:0] rq, input int g, input bit tog, input int spur,
                         input int hold, input int exp_lat, input logic [15:0] c);
    int  lat, k, ecnt, cyc;
    bit  ok, spur_done;
    logic [N-1:0] hs;
    req = rq;
    lat = 0;
    while (grant == '0 && lat < 20) begin tick(); lat++; end
    chk("grant", int'(grant), 1 << g);
    if (exp_lat > 0) chk("grant_latency", lat, exp_lat);

    k = 0; ecnt = 0; cyc = 0; ok = 1; spur_done = 0;
    while (ecnt < POINTS && cyc < 400) begin
      pvalid = '0; px = '1; py = '1;
      if (k < POINTS) begin
        px[4*g +: 4] = 4'(k % 16);
        py[4*g +: 4] = 4'(k / 16);
        if (!tog || cyc % 2 == 0) pvalid[g] = 1'b1;
      end
      ENG_DONE = (k == spur && !spur_done);
      if (ENG_DONE) spur_done = 1;
      #1;
      if (pready !== ((k < POINTS) ? (N'(1) << g) : N'(0))) ok = 0;
      hs = pvalid & pready;
      tick();
      cyc++;
      ENG_DONE = 1'b0;
      if (hs != '0) k++;
      if (ENG_VALID) begin
        if (ENG_X != 4'(ecnt % 16) || ENG_Y != 4'(ecnt / 16)) ok = 0;
        ecnt++;
      end
    end
    pvalid = '0;
    chk("load_ready_and_data", int'(ok), 1);
    chk("eng_pulses", ecnt, POINTS);
    chk("wait_pready_low", int'(pready), 0);

    ok = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (ENG_VALID || res_valid || grant != (N'(1) << g)) ok = 0;
    end
    chk("wait_done_quiet", int'(ok), 1);

    ENG_DONE = 1'b1;
    {ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y} = c;
    tick();
    ENG_DONE = 1'b0;
    {ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y} = ~c;
    chk("res_valid", int'(res_valid), 1);
    chk("res_id", int'(res_id), g);
    chk("res_data", int'({res_c1x, res_c1y, res_c2x, res_c2y}), int'(c));

    if (hold > 0) begin
      req = '1;
      ok  = 1;
      for (int i = 0; i < hold; i++) begin
        tick();
        if (!res_valid || res_id != 1'(g) || {res_c1x, res_c1y, res_c2x, res_c2y} != c ||
            grant != (N'(1) << g) || pready != '0 || ENG_VALID) ok = 0;
      end
      chk("resp_hold_stable", int'(ok), 1);
      req = rq;
    end

    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("res_valid_cleared", int'(res_valid), 0);
    chk("grant_cleared", int'(grant), 0);
  endtask

  typedef struct {
    logic [N-1:0] rq;
    int           g;
    bit           tog;
    int           spur;
    int           hold;
    int           lat;
    logic [15:0]  c;
    bit           err;
  } vec_t;

  vec_t tbl[8];

  typedef struct {
    int          id;
    logic [15:0] c;
  } res_e;

  initial begin
    int          n, exp_id, ptr, ecnt, timer, pr_bad;
    bit          armed, done;
    int          pend[N];
    int          last, cur;
    logic [3:0]  jx[POINTS], jy[POINTS];
    logic [N-1:0] prev_grant, hs;
    logic [15:0] rc;
    res_e        expq[$];
    res_e        e;

    RST = 1'b1; req = '0; pvalid = '0; px = '0; py = '0; ENG_DONE = 1'b0;
    {ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y} = '0; res_ready = 1'b0;
    tick(); tick();
    chk("reset_outputs", all_outs(), 0);
    RST = 1'b0;

    //           rq     g  tog spur hold lat  C1x C1y C2x C2y   err
    tbl[0] = '{2'b01, 0, 0, -1,  0,  0, 16'h3497, 0};
    tbl[1] = '{2'b11, 1, 0, -1,  0,  1, 16'h1234, 0};
    tbl[2] = '{2'b11, 0, 0, -1,  0,  1, 16'hA5C3, 0};
    tbl[3] = '{2'b01, 0, 1, -1,  0,  1, 16'h0F0F, 0};
    tbl[4] = '{2'b01, 0, 0, -1, 10,  1, 16'h7E81, 0};
    tbl[5] = '{2'b10, 1, 0, -1,  0,  1, 16'h5566, 0};
    tbl[6] = '{2'b11, 0, 0, 12,  0,  1, 16'hBEEF, 1};
    tbl[7] = '{2'b10, 1, 0, -1,  0,  1, 16'hC0DE, 1};

    for (int t = 0; t < 8; t++) begin
      run_job(tbl[t].rq, tbl[t].g, tbl[t].tog, tbl[t].spur, tbl[t].hold, tbl[t].lat, tbl[t].c);
      chk("err_spurious", int'(err_spurious), int'(tbl[t].err));
    end

    // Reset in the middle of a load: everything clears, then a clean restart.
    req = 2'b01;
    n = 0;
    while (grant == '0 && n < 20) begin tick(); n++; end
    chk("rst_pre_grant", int'(grant), 1);
    for (int i = 0; i < 20; i++) begin
      pvalid = 2'b01; px = '1; py = '1;
      px[3:0] = 4'(i); py[3:0] = 4'd0;
      tick();
    end
    pvalid = '0;
    chk("rst_mid_load_valid", int'(ENG_VALID), 1);
    RST = 1'b1;
    #1;
    chk("rst_async_outputs", all_outs(), 0);
    tick(); tick();
    RST = 1'b0;
    run_job(2'b01, 0, 0, -1, 0, IW + 1, 16'h6A2D);
    chk("rst_err_clear", int'(err_spurious), 0);

    // Randomized traffic against a transaction-level model.
    RST = 1'b1; req = '0;
    tick();
    RST = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = $urandom_range(1, 3);
    last = N - 1; cur = 0; ptr = 0; ecnt = 0; armed = 0; timer = 0; pr_bad = 0;
    done = 0; prev_grant = '0; hs = '0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      for (int i = 0; i < N; i++) req[i] = (pend[i] > 0);
      if (hs != '0) ptr++;
      if (grant != '0 && prev_grant == '0) begin
        exp_id = -1;
        for (int i = 1; i <= N; i++)
          if (exp_id < 0 && pend[(last + i) % N] > 0) exp_id = (last + i) % N;
        chk("rand_grant", int'(grant), 1 << exp_id);
        cur = exp_id; ptr = 0;
        for (int i = 0; i < POINTS; i++) begin
          jx[i] = 4'($urandom); jy[i] = 4'($urandom);
        end
      end
      prev_grant = grant;
      if (ENG_VALID) begin
        chk("rand_eng_point", int'({ENG_X, ENG_Y}), int'({jx[ecnt], jy[ecnt]}));
        ecnt++;
        if (ecnt == POINTS) begin ecnt = 0; armed = 1; timer = $urandom_range(0, 4); end
      end
      ENG_DONE = 1'b0;
      if (armed) begin
        if (timer == 0) begin
          rc = 16'($urandom);
          ENG_DONE = 1'b1;
          {ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y} = rc;
          expq.push_back('{cur, rc});
          armed = 0;
        end else begin
          timer--;
        end
      end
      res_ready = 1'($urandom_range(0, 1));
      pvalid = N'($urandom); px = 8'($urandom); py = 8'($urandom);
      if (ptr < POINTS) begin
        px[4*cur +: 4] = jx[ptr];
        py[4*cur +: 4] = jy[ptr];
      end
      #1;
      if ((pready & ~grant) != '0 || $countones(pready) > 1) pr_bad++;
      hs = pvalid & pready;
      if (res_valid && res_ready) begin
        if (expq.size() == 0) begin
          chk("rand_res_unexpected", expq.size(), 1);
        end else begin
          e = expq.pop_front();
          chk("rand_res_id", int'(res_id), e.id);
          chk("rand_res_data", int'({res_c1x, res_c1y, res_c2x, res_c2y}), int'(e.c));
          pend[e.id]--;
          last = e.id;
        end
      end
      done = (expq.size() == 0) && !armed;
      for (int i = 0; i < N; i++) if (pend[i] > 0) done = 0;
      tick();
    end
    res_ready = 1'b0; ENG_DONE = 1'b0; pvalid = '0; req = '0;
    chk("rand_complete", int'(done), 1);
    chk("rand_pready_onehot", pr_bad, 0);
    chk("rand_err_spurious", int'(err_spurious), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/laser_job_sched.md
Name: laser_job_sched

Overview:
- Shares one two-circle coverage engine (40-point load, one-cycle DONE pulse with C1/C2 result) among NUM_REQ requesters.
- Each requester streams a 40-point job through a valid/ready port.
- The block round-robin arbitrates, forwards points to the engine and waits for DONE.
- It returns the circle centres tagged with the requester id over a valid/ready result port.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ID_W, 1, width of res_id; equals clog2(NUM_REQ), minimum 1
POINTS, 40, points per job; must match engine load count
INIT_WAIT, 2, cycles after reset before the first point is forwarded (engine IDLE->READ)

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
req  in  NUM_REQ  per-requester job request, level
grant  out  NUM_REQ  one-hot, registered; high for the granted requester from LOAD through RESP
pvalid  in  NUM_REQ  point valid per requester
px  in  4*NUM_REQ  point X, requester i at [4i+3:4i]
py  in  4*NUM_REQ  point Y, same packing
pready  out  NUM_REQ  point accept per requester
ENG_X  out  4  point X to engine
ENG_Y  out  4  point Y to engine
ENG_VALID  out  1  point strobe to engine
ENG_DONE  in  1  engine completion pulse
ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y  in  4 each  engine result, valid while ENG_DONE=1
res_valid  out  1  result available
res_ready  in  1  result consumer accept
res_id  out  ID_W  requester index owning the result
res_c1x, res_c1y, res_c2x, res_c2y  out  4 each  captured result
err_spurious  out  1  sticky: ENG_DONE seen outside WAIT_DONE

Behaviour:
- Reset values: all outputs 0; state INIT; RR pointer selects requester 0 as highest priority; beat counter 0.
- INIT: count INIT_WAIT cycles, then go to ARB.
- ARB: if any req bit is set, grant the first set bit searching from last_grant+1 with wrap. Register grant and go to LOAD next cycle. With no request, stay in ARB.
- LOAD:
  - pready[g] = pvalid-independent combinational 1 while beat_cnt < POINTS; all other pready bits are 0.
  - A beat is accepted when pvalid[g] & pready[g].
  - ENG_X/ENG_Y/ENG_VALID are registered from the accepted beat: engine sees it one cycle later. ENG_VALID is 0 in every cycle with no accepted beat.
  - Gaps in pvalid are allowed.
  - On accepting beat POINTS-1: beat_cnt clears and the state goes to WAIT_DONE.
  - Dropping req mid-LOAD has no effect; the job is not complete until POINTS beats are accepted.
- WAIT_DONE: on ENG_DONE=1, capture ENG_C1X..C2Y into res_*, set res_id=g, res_valid=1, go to RESP. No timeout.
- RESP:
  - Hold res_* stable while res_valid & ~res_ready.
  - On res_valid & res_ready: clear res_valid and grant, update last_grant=g, go to ARB.
  - The next grant appears no earlier than the cycle after the handshake.
- ENG_DONE in any state other than WAIT_DONE: ignored for data, sets err_spurious. err_spurious clears only on RST.
- The engine re-enters its load state in the same cycle as DONE, so no extra wait is needed before the next job's first point.
- Simultaneous requests: strict round robin. A requester that just completed has lowest priority in the next ARB.
- Reset mid-LOAD/WAIT_DONE (engine shares RST): abort immediately; partial job discarded; no result emitted; restart in INIT.
- beat_cnt width: 6 bits (covers 0..POINTS-1); wraps only by explicit clear.

Decomposition:
- Shared package laser_pkg: COORD_W=4, POINTS=40, state encoding (INIT, ARB, LOAD, WAIT_DONE, RESP). The engine should use the same POINTS constant.
- One sub-module, laser_rr_arb: combinational round-robin pick from req and last_grant, producing a one-hot grant and the index.

Test Plan:
- Single job, req=01, 40 points (x=i%16, y=i/16), pvalid continuous -> pready[0] high 40 cycles; ENG_VALID 40 pulses delayed 1 cycle; model DONE with C1=(3,4), C2=(9,7) -> res_valid, res_id=0, res_c1x=3, res_c1y=4, res_c2x=9, res_c2y=7.
- req=11 held across 3 jobs -> grant order 01, 10, 01; res_id 0, 1, 0; pready never high for both requesters.
- pvalid[0] toggling every other cycle -> still exactly 40 ENG_VALID pulses; WAIT_DONE entered after the 40th accepted beat only.
- res_ready held low 10 cycles after DONE -> res_* stable, grant held, no new LOAD even with req=10; ready=1 -> next grant to requester 1 one cycle later.
- ENG_DONE pulsed during LOAD beat 12 -> err_spurious=1 sticky; load continues to 40 beats; the real DONE result is delivered normally.
- RST asserted in LOAD after 20 beats -> outputs 0 immediately; after release, INIT_WAIT cycles then ARB; a full new job of 40 beats completes correctly.
